// File: rtl/sysid_probe_master.sv
// sysid_probe_master: Avalon-MM initiator that reads sysid word 0 (ID) and word 1 (timestamp),
// checks them against expected values and reports pass/mismatch/timeout status.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS = 32'd1427328404,
  parameter int          TIMEOUT_W   = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  localparam logic [1:0] IDLE = 2'd0, RD_ID = 2'd1, RD_TS = 2'd2;
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {TIMEOUT_W{1'b1}} - 1'b1;
  logic [1:0]           state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 expire;
  // the cycle that would make the count reach all-ones while still stalled
  assign expire = avm_waitrequest && wait_cnt == WAIT_LAST;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state       <= RD_ID;
          wait_cnt    <= '0;
          avm_address <= 1'b0;
          avm_read    <= 1'b1;
          busy        <= 1'b1;
          pass        <= 1'b0;
          id_mismatch <= 1'b0;
          ts_mismatch <= 1'b0;
          timeout     <= 1'b0;
        end
      end else if (expire) begin
        state       <= IDLE;
        avm_address <= 1'b0;
        avm_read    <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        pass        <= 1'b0;
        timeout     <= 1'b1;
      end else if (avm_waitrequest) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else if (state == RD_ID) begin
        state       <= RD_TS;
        wait_cnt    <= '0;
        avm_address <= 1'b1;
        id_value    <= avm_readdata;
        id_mismatch <= avm_readdata != EXPECTED_ID;
      end else begin
        state       <= IDLE;
        avm_address <= 1'b0;
        avm_read    <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        ts_value    <= avm_readdata;
        ts_mismatch <= avm_readdata != EXPECTED_TS;
        pass        <= !id_mismatch && avm_readdata == EXPECTED_TS;
      end
    end
endmodule

// File: tb/tb_sysid_probe_master.sv
// tb_sysid_probe_master: randomized Avalon slave plus a timeline model of each check.
module tb_sysid_probe_master;
  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1427328404;
  localparam int TW = 4, LIM = 15;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic avm_waitrequest = 1'b0;
  logic avm_address, avm_read, busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  sysid_probe_master #(.EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_W(TW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .pass(pass), .id_mismatch(id_mismatch),
    .ts_mismatch(ts_mismatch), .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  int tests = 0, fails = 0, cyc = 0;
  int w0 = 0, w1 = 0;
  logic [31:0] d0 = '0, d1 = '0;
  // current check plan: start edge, done cycle, wait counts, data, outcome class
  logic p_valid = 1'b0, p_to0 = 1'b0, p_to = 1'b0;
  int p_s = -100, p_e = -100, p_w0 = 0;
  logic [31:0] p_d0 = '0, p_d1 = '0, prev_id = '0, prev_ts = '0;

  function automatic logic id_seen(int c);
    return p_valid && !p_to0 && c >= p_s + 2 + p_w0;
  endfunction
  function automatic logic [31:0] exp_id(int c);
    return id_seen(c) ? p_d0 : prev_id;
  endfunction
  function automatic logic [31:0] exp_ts(int c);
    return (p_valid && c >= p_e && !p_to) ? p_d1 : prev_ts;
  endfunction

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      p_valid = 1'b0; p_to0 = 1'b0; p_to = 1'b0;
      p_s = -100; p_e = -100; p_w0 = 0;
      p_d0 = '0; p_d1 = '0; prev_id = '0; prev_ts = '0;
    end else begin
      if (start && (!p_valid || cyc >= p_e)) begin
        prev_id = exp_id(cyc);
        prev_ts = exp_ts(cyc);
        p_valid = 1'b1; p_s = cyc; p_w0 = w0; p_d0 = d0; p_d1 = d1;
        p_to0 = w0 >= LIM;
        p_to  = p_to0 || w1 >= LIM;
        p_e   = p_to0 ? cyc + 1 + LIM : (w1 >= LIM ? cyc + 2 + w0 + LIM : cyc + 3 + w0 + w1);
      end
      cyc++;
    end
  end

  // slave: stall for the planned number of cycles per read, garbage data otherwise
  int scnt = 0;
  logic wr;
  initial forever begin
    @(negedge clock);
    if (avm_read) begin
      wr = scnt < (avm_address ? w1 : w0);
      avm_waitrequest = wr;
      avm_readdata = wr ? $urandom : (avm_address ? d1 : d0);
      scnt = wr ? scnt + 1 : 0;
    end else begin
      scnt = 0;
      avm_waitrequest = 1'($urandom_range(1));
      avm_readdata = $urandom;
    end
  end

  logic [71:0] act_v, exp_v;
  logic e_busy, e_fin, e_idmm, e_tsmm;
  initial forever begin
    @(negedge clock);
    e_busy = p_valid && cyc > p_s && cyc < p_e;
    e_fin  = p_valid && cyc >= p_e;
    e_idmm = id_seen(cyc) && p_d0 != EXP_ID;
    e_tsmm = e_fin && !p_to && p_d1 != EXP_TS;
    exp_v = {e_busy, e_busy && id_seen(cyc), e_busy, p_valid && cyc == p_e,
             e_fin && !p_to && !e_idmm && !e_tsmm, e_idmm, e_tsmm, e_fin && p_to,
             exp_id(cyc), exp_ts(cyc)};
    act_v = {avm_read, avm_address && e_busy, busy, done, pass, id_mismatch, ts_mismatch,
             timeout, id_value, ts_value};
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL cycle %0d outputs got %h expected %h", cyc, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  task automatic run(input int a, input int b, input logic [31:0] x, input logic [31:0] y,
                     output int k);
    @(negedge clock);
    w0 = a; w1 = b; d0 = x; d1 = y;
    start = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      start = 1'b0;
    end while (!done && k < 60);
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(15);
    return r == 15 ? LIM : r == 14 ? 255 : r > 10 ? int'($urandom_range(14)) : int'($urandom_range(2));
  endfunction

  int k;
  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_pass", 32'(pass), 0);
    chk("reset_ts_value", ts_value, 0);

    run(0, 0, EXP_ID, EXP_TS, k);
    chk("zw_latency", k, 3);
    chk("zw_pass", 32'(pass), 1);
    chk("zw_id_value", id_value, 32'h0);
    chk("zw_ts_value", ts_value, 32'd1427328404);

    run(0, 0, EXP_ID, 32'h1234_5678, k);
    chk("badts_pass", 32'(pass), 0);
    chk("badts_ts_mm", 32'(ts_mismatch), 1);
    chk("badts_id_mm", 32'(id_mismatch), 0);
    chk("badts_ts_value", ts_value, 32'h1234_5678);

    run(5, 5, EXP_ID, EXP_TS, k);
    chk("wait5_latency", k, 13);
    chk("wait5_pass", 32'(pass), 1);

    run(0, 255, 32'hDEAD_BEEF, 32'h1111_1111, k);
    chk("to_latency", k, 17);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_pass", 32'(pass), 0);
    chk("to_id_value", id_value, 32'hDEAD_BEEF);
    chk("to_ts_value", ts_value, EXP_TS);

    // start while busy is ignored; start in the done cycle begins a new check
    @(negedge clock);
    w0 = 0; w1 = 0; d0 = EXP_ID; d1 = 32'h0BAD_0BAD;
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock);
    chk("rs_done_first", 32'(done), 1);
    chk("rs_ts_mm_first", 32'(ts_mismatch), 1);
    d1 = EXP_TS;
    @(negedge clock); start = 1'b0;
    chk("rs_busy_again", 32'(busy), 1);
    chk("rs_flags_cleared", 32'(ts_mismatch), 0);
    repeat (2) @(negedge clock);
    chk("rs_done_second", 32'(done), 1);
    chk("rs_pass_second", 32'(pass), 1);

    // asynchronous reset in the middle of a stalled read
    @(negedge clock);
    w0 = 255; w1 = 0; start = 1'b1;
    repeat (4) @(negedge clock) start = 1'b0;
    chk("ar_read_before", 32'(avm_read), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_read", 32'(avm_read), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_ts_value", ts_value, 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    run(0, 0, EXP_ID, EXP_TS, k);
    chk("ar_latency", k, 3);
    chk("ar_pass", 32'(pass), 1);

    repeat (1500) begin
      @(negedge clock);
      if (!p_valid || cyc >= p_e) begin
        w0 = pick_wait(); w1 = pick_wait();
        d0 = $urandom_range(1) ? EXP_ID : $urandom;
        d1 = $urandom_range(1) ? EXP_TS : $urandom;
      end
      start = $urandom_range(3) == 0;
    end
    start = 1'b0;
    repeat (60) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
